// File: rtl/matmul_pkg.sv
// =============================================================================
// Module      : matmul_pkg
// Description : Shared types and sizing helpers for the matmul result drain.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package matmul_pkg;

    localparam int DEFAULT_DIM   = 16;
    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_LANES = 4;

    localparam int BEATS         = DEFAULT_DIM * DEFAULT_DIM / DEFAULT_LANES;
    localparam int BEATS_PER_ROW = DEFAULT_DIM / DEFAULT_LANES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } drain_state_t;

    typedef logic [2*DEFAULT_WIDTH-1:0] result_elem_t;

    // Width of a beat index; a single-beat stream still needs one bit.
    function automatic int beat_index_width(input int dim, input int lanes);
        int n;
        n = dim * dim / lanes;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/drain_beat_counter.sv
// =============================================================================
// Module      : drain_beat_counter
// Description : Beat index, row/column position and last-beat flag for the drain.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module drain_beat_counter
    import matmul_pkg::*;
#(
    parameter int DIM   = DEFAULT_DIM,
    parameter int LANES = DEFAULT_LANES
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     clear,
    input  logic                                     advance,
    output logic [beat_index_width(DIM, LANES)-1:0]  beat_idx,
    output logic [$clog2(DIM)-1:0]                   row,
    output logic [$clog2(DIM)-1:0]                   col,
    output logic                                     last
);

    localparam int c_beats  = DIM * DIM / LANES;
    localparam int c_beat_w = beat_index_width(DIM, LANES);
    localparam int c_col_w  = $clog2(DIM);

    logic [c_beat_w-1:0] r_beat;
    logic [c_col_w-1:0]  r_row;
    logic [c_col_w-1:0]  r_col;
    logic                w_at_last;

    assign w_at_last = (r_beat == c_beat_w'(c_beats - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_beat <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (advance) begin
            if (w_at_last) begin
                r_beat <= '0;
                r_row  <= '0;
                r_col  <= '0;
            end else begin
                r_beat <= r_beat + c_beat_w'(1);
                // Column walks in LANES-wide steps and wraps into the next row.
                if (r_col == c_col_w'(DIM - LANES)) begin
                    r_col <= '0;
                    r_row <= r_row + c_col_w'(1);
                end else begin
                    r_col <= r_col + c_col_w'(LANES);
                end
            end
        end
    end

    assign beat_idx = r_beat;
    assign row      = r_row;
    assign col      = r_col;
    assign last     = w_at_last;

endmodule

`default_nettype wire

// File: rtl/matmul_result_drain.sv
// =============================================================================
// Module      : matmul_result_drain
// Description : Sequences one multiply job, snapshots the result and streams it.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module matmul_result_drain
    import matmul_pkg::*;
#(
    parameter int DIM   = DEFAULT_DIM,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LANES = DEFAULT_LANES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic                           mult_reset_n,
    input  logic                           mult_finished,
    input  logic [DIM*DIM*2*WIDTH-1:0]     mult_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*2*WIDTH-1:0]       out_data,
    output logic [$clog2(DIM)-1:0]         out_row,
    output logic [$clog2(DIM)-1:0]         out_col,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output logic [31:0]                    run_cycles
);

    localparam int c_elem_w    = 2 * WIDTH;
    localparam int c_beats     = DIM * DIM / LANES;
    localparam int c_beat_bits = LANES * c_elem_w;
    localparam int c_beat_w    = beat_index_width(DIM, LANES);

    generate
        if (DIM % LANES != 0) begin : g_lanes_check
            $error("matmul_result_drain: DIM must be a multiple of LANES");
        end
    endgenerate

    drain_state_t                 r_state;
    logic                         r_first_run;
    logic                         r_mult_reset_n;
    logic                         r_out_valid;
    logic                         r_busy;
    logic                         r_done;
    logic [31:0]                  r_run_cycles;
    logic [DIM*DIM*c_elem_w-1:0]  r_snapshot;

    logic                         w_fire;
    logic                         w_take;
    logic                         w_start;
    logic                         w_last;
    logic [c_beat_w-1:0]          w_beat_idx;
    logic [c_beat_bits-1:0]       w_beats [c_beats];

    assign w_fire  = r_out_valid && out_ready;
    // The finished flag may still be high from the previous job during the first RUN cycle.
    assign w_take  = (r_state == RUN) && !r_first_run && mult_finished;
    assign w_start = (r_state == IDLE) && start && !r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_first_run    <= 1'b0;
            r_mult_reset_n <= 1'b0;
            r_out_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_run_cycles   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state        <= RUN;
                        r_first_run    <= 1'b1;
                        r_mult_reset_n <= 1'b1;
                        r_busy         <= 1'b1;
                        r_run_cycles   <= '0;
                    end
                end
                RUN: begin
                    r_first_run <= 1'b0;
                    if (r_run_cycles != 32'hFFFF_FFFF) begin
                        r_run_cycles <= r_run_cycles + 32'd1;
                    end
                    if (w_take) begin
                        r_state        <= DRAIN;
                        r_mult_reset_n <= 1'b0;
                        r_out_valid    <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_fire && w_last) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_mult_reset_n <= 1'b0;
                    r_out_valid    <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_take) begin
            r_snapshot <= mult_out;
        end
    end

    drain_beat_counter #(
        .DIM   (DIM),
        .LANES (LANES)
    ) u_beat_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_start),
        .advance  (w_fire),
        .beat_idx (w_beat_idx),
        .row      (out_row),
        .col      (out_col),
        .last     (w_last)
    );

    // Row-major layout means beat b is simply the b-th LANES-element slice.
    generate
        for (genvar b = 0; b < c_beats; b++) begin : g_beats
            assign w_beats[b] = r_snapshot[b*c_beat_bits +: c_beat_bits];
        end
    endgenerate

    assign out_data     = w_beats[w_beat_idx];
    assign out_last     = r_out_valid && w_last;
    assign out_valid    = r_out_valid;
    assign mult_reset_n = r_mult_reset_n;
    assign busy         = r_busy;
    assign done         = r_done;
    assign run_cycles   = r_run_cycles;

endmodule

`default_nettype wire

// File: tb/tb_matmul_result_drain.sv
// =============================================================================
// Module      : tb_matmul_result_drain
// Description : Self-checking bench for matmul_result_drain (DIM=4, LANES=2).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_matmul_result_drain;

    localparam int DIM   = 4;
    localparam int WIDTH = 4;
    localparam int LANES = 2;
    localparam int EW    = 2 * WIDTH;

    typedef struct {
        int                     row;
        int                     col;
        logic [LANES*EW-1:0]    data;
        bit                     last;
    } beat_t;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic                       mult_reset_n;
    logic                       mult_finished;
    logic [DIM*DIM*EW-1:0]      mult_out;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*EW-1:0]        out_data;
    logic [1:0]                 out_row;
    logic [1:0]                 out_col;
    logic                       out_last;
    logic                       busy;
    logic                       done;
    logic [31:0]                run_cycles;

    logic [EW-1:0]              mat [DIM][DIM];
    int                         n_cmp  = 0;
    int                         n_fail = 0;

    always #5 clk = ~clk;

    matmul_result_drain #(
        .DIM   (DIM),
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .mult_reset_n  (mult_reset_n),
        .mult_finished (mult_finished),
        .mult_out      (mult_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_row       (out_row),
        .out_col       (out_col),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done),
        .run_cycles    (run_cycles)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pack_matrix();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                mult_out[(r*DIM + c)*EW +: EW] = mat[r][c];
    endtask

    task automatic fill_random();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                mat[r][c] = EW'($urandom);
    endtask

    // ready_mode: 0 always ready, 1 pattern 1,0,0,..., 2 random
    task automatic run_job(input int fin, input int ready_mode, input bit early_fin,
                           input bit hold_start, input int abort_after);
        beat_t exp_q[$];
        beat_t b;
        int    popped;
        int    guard;
        bit    rdy;

        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c += LANES) begin
                b.row  = r;
                b.col  = c;
                b.data = '0;
                for (int l = 0; l < LANES; l++)
                    b.data[l*EW +: EW] = mat[r][c+l];
                b.last = (r == DIM-1) && (c == DIM-LANES);
                exp_q.push_back(b);
            end
        end
        pack_matrix();

        start = 1'b1;
        for (int k = 1; k <= fin; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("run_mult_reset_n", mult_reset_n, 1'b1);
            check("run_out_valid", out_valid, 1'b0);
            check("run_busy", busy, 1'b1);
            mult_finished = (k == fin) || (early_fin && k == 1);
        end
        @(negedge clk);
        mult_finished = 1'b0;
        mult_out = {$urandom, $urandom, $urandom, $urandom};
        start = hold_start;
        check("run_cycles", run_cycles, 64'(fin));
        check("drain_mult_reset_n", mult_reset_n, 1'b0);

        popped = 0;
        guard  = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            b = exp_q[0];
            check("beat_valid", out_valid, 1'b1);
            check("beat_row", out_row, 64'(b.row));
            check("beat_col", out_col, 64'(b.col));
            check("beat_data", out_data, 64'(b.data));
            check("beat_last", out_last, 64'(b.last));
            check("drain_busy", busy, 1'b1);
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (guard % 3 == 0);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            out_ready = rdy;
            if (rdy) begin
                void'(exp_q.pop_front());
                popped++;
            end
            guard++;
            @(negedge clk);
            if (abort_after > 0 && popped == abort_after) begin
                reset     = 1'b1;
                out_ready = 1'b0;
                start     = 1'b0;
                @(negedge clk);
                check("abort_out_valid", out_valid, 1'b0);
                check("abort_out_last", out_last, 1'b0);
                check("abort_busy", busy, 1'b0);
                check("abort_run_cycles", run_cycles, 64'd0);
                reset = 1'b0;
                return;
            end
        end
        if (guard >= 200)
            check("drain_timeout", 1'b1, 1'b0);

        out_ready = 1'b0;
        check("end_out_valid", out_valid, 1'b0);
        check("end_done", done, 1'b1);
        check("end_busy", busy, 1'b0);
        check("end_run_cycles_held", run_cycles, 64'(fin));
        @(negedge clk);
        start = 1'b0;
        check("post_done_pulse", done, 1'b0);
        check("post_busy", busy, 1'b0);
        check("post_mult_reset_n", mult_reset_n, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        mult_finished = 1'b0;
        out_ready     = 1'b0;
        mult_out      = '0;

        repeat (3) @(negedge clk);
        check("rst_mult_reset_n", mult_reset_n, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_run_cycles", run_cycles, 64'd0);
        check("rst_done", done, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // basic job: element (r,c) = r*4+c, finished 6 cycles after start
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                mat[r][c] = EW'(r*DIM + c);
        run_job(6, 0, 1'b0, 1'b0, 0);

        // finished flag while idle must not start anything
        mult_finished = 1'b1;
        @(negedge clk);
        mult_finished = 1'b0;
        check("idle_fin_busy", busy, 1'b0);
        check("idle_fin_valid", out_valid, 1'b0);
        @(negedge clk);

        // backpressure with a post-snapshot mult_out change
        fill_random();
        run_job(4, 1, 1'b0, 1'b0, 0);

        // early finished flag ignored, start held through drain and done
        fill_random();
        run_job(5, 0, 1'b1, 1'b1, 0);

        // reset after 3 beats, then a clean job from beat 0
        fill_random();
        run_job(3, 0, 1'b0, 1'b0, 3);
        fill_random();
        run_job(3, 0, 1'b0, 1'b0, 0);

        // negative elements pass through bit-exact
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                mat[r][c] = 8'hF0;
        run_job(2, 2, 1'b0, 1'b0, 0);

        repeat (6) begin
            fill_random();
            run_job(int'($urandom_range(2, 9)), 2, 1'b0, 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
